alu_result_stage: RTL and testbench

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

---
 rtl/alu_result_if.sv | 32 +++
 rtl/alu_result_stage.sv | 86 ++++++++
 tb/tb_alu_result_stage.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/alu_result_if.sv
// Handshake bundle between an adder-subtractor, the alu_result_stage and its consumer.
// Slave modport is the stage's view; master modport drives the stage.
interface alu_result_if #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic             in_mode;
    logic             in_op1_msb;
    logic             in_op2_msb;
    logic [WIDTH-1:0] in_result;
    logic             in_carry_out;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       out_flags;
    logic             clr_count;
    logic [CNT_W-1:0] ovf_count;

    modport slave (
        input  in_valid, in_mode, in_op1_msb, in_op2_msb, in_result, in_carry_out,
        input  out_ready, clr_count,
        output in_ready, out_valid, out_result, out_flags, ovf_count
    );

    modport master (
        output in_valid, in_mode, in_op1_msb, in_op2_msb, in_result, in_carry_out,
        output out_ready, clr_count,
        input  in_ready, out_valid, out_result, out_flags, ovf_count
    );
endinterface

// File: rtl/alu_result_stage.sv
// Flag generation plus 2-entry output FIFO and saturating overflow counter for an adder-subtractor.
// Optional macro ALU_RESULT_SAT_EN clamps overflowing results to the signed extreme.
module alu_result_stage #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input logic          clk,
    input logic          rst,
    alu_result_if.slave  bus
);
    localparam int EW = WIDTH + 4;

    logic [EW-1:0]    mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;
    logic [CNT_W-1:0] ovf_cnt;

    logic             push;
    logic             pop;
    logic             ovf;
    logic             carry;
    logic [WIDTH-1:0] final_result;
    logic [3:0]       flags;

    assign bus.in_ready  = (count < 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_comb begin
        carry = bus.in_carry_out;
        ovf   = 1'b0;
        if (bus.in_mode)
            ovf = (bus.in_op1_msb != bus.in_op2_msb) && (bus.in_result[WIDTH-1] != bus.in_op1_msb);
        else
            ovf = (bus.in_op1_msb == bus.in_op2_msb) && (bus.in_result[WIDTH-1] != bus.in_op1_msb);
    end

`ifdef ALU_RESULT_SAT_EN
    always_comb begin
        final_result = bus.in_result;
        if (ovf)
            final_result = bus.in_op1_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`else
    assign final_result = bus.in_result;
`endif

    assign flags = {final_result[WIDTH-1], (final_result == '0), carry, ovf};

    // Head entry drives the outputs directly, so it stays put while stalled.
    assign bus.out_result = mem[rd_ptr][EW-1:4];
    assign bus.out_flags  = mem[rd_ptr][3:0];
    assign bus.ovf_count  = ovf_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++)
                mem[i] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {final_result, flags};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            if (push && !pop)
                count <= count + 2'd1;
            else if (pop && !push)
                count <= count - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_cnt <= '0;
        else if (bus.clr_count)
            ovf_cnt <= '0;
        else if (push && ovf && (ovf_cnt != '1))
            ovf_cnt <= ovf_cnt + 1'b1;
    end
endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized and directed bench for alu_result_stage against a queue-based arithmetic reference.
module tb_alu_result_stage;
    localparam int W     = 64;
    localparam int CW    = 16;
    localparam int CMAX  = (1 << CW) - 1;
    localparam logic [W-1:0] MAXPOS = {1'b0, {(W-1){1'b1}}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    logic [W+3:0] q [$];
    int           cnt_model = 0;

    alu_result_if #(.WIDTH(W), .CNT_W(CW)) bus ();
    alu_result_stage #(.WIDTH(W), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, want finish)");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Returns {V, raw_result, C} from full-width signed/unsigned arithmetic.
    function automatic logic [W+1:0] arith(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W:0] sa, sb, sr;
        logic [W:0] u;
        logic c;
        sa = signed'({a[W-1], a});
        sb = signed'({b[W-1], b});
        if (!m) begin
            u  = {1'b0, a} + {1'b0, b};
            sr = sa + sb;
            c  = u[W];
        end else begin
            u  = {1'b0, a} - {1'b0, b};
            sr = sa - sb;
            c  = (a >= b);
        end
        return {(sr > signed'({1'b0, MAXPOS})) || (sr < -signed'({1'b0, MAXPOS}) - 1), u[W-1:0], c};
    endfunction

    // One clock: check outputs against the model, drive inputs, advance the model, step.
    task automatic cycle(input logic v, input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ordy, input logic clr);
        logic [W+1:0] r;
        logic         ovf, c, push, pop;
        logic [W-1:0] res;
        check_eq("out_valid", W'(bus.out_valid), W'(q.size() != 0));
        check_eq("in_ready", W'(bus.in_ready), W'(q.size() < 2));
        check_eq("ovf_count", W'(bus.ovf_count), W'(cnt_model));
        if (q.size() != 0) begin
            check_eq("out_result", bus.out_result, q[0][W+3:4]);
            check_eq("out_flags", W'(bus.out_flags), W'(q[0][3:0]));
        end
        r   = arith(m, a, b);
        ovf = r[W+1];
        res = r[W:1];
        c   = r[0];
        bus.in_valid     = v;
        bus.in_mode      = m;
        bus.in_op1_msb   = a[W-1];
        bus.in_op2_msb   = b[W-1];
        bus.in_result    = res;
        bus.in_carry_out = c;
        bus.out_ready    = ordy;
        bus.clr_count    = clr;
        push = v && (q.size() < 2);
        pop  = ordy && (q.size() != 0);
`ifdef ALU_RESULT_SAT_EN
        if (ovf) res = a[W-1] ? ~MAXPOS : MAXPOS;
`endif
        if (pop) void'(q.pop_front());
        if (push) q.push_back({res, res[W-1], res == '0, c, ovf});
        if (clr) cnt_model = 0;
        else if (push && ovf && cnt_model < CMAX) cnt_model++;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] a, b;
        bus.in_valid = 0; bus.in_mode = 0; bus.in_op1_msb = 0; bus.in_op2_msb = 0;
        bus.in_result = '0; bus.in_carry_out = 0; bus.out_ready = 0; bus.clr_count = 0;
        repeat (2) @(negedge clk);
        check_eq("rst_out_valid", W'(bus.out_valid), '0);
        check_eq("rst_in_ready", W'(bus.in_ready), W'(1));
        check_eq("rst_out_result", bus.out_result, '0);
        check_eq("rst_out_flags", W'(bus.out_flags), '0);
        check_eq("rst_ovf_count", W'(bus.ovf_count), '0);
        rst = 1'b0;

        // Signed overflow on add, accepted on first edge after reset.
        cycle(1, 0, MAXPOS, W'(1), 1, 0);
`ifdef ALU_RESULT_SAT_EN
        check_eq("ovf_add_result", bus.out_result, MAXPOS);
        check_eq("ovf_add_flags", W'(bus.out_flags), W'(4'b0001));
`else
        check_eq("ovf_add_result", bus.out_result, ~MAXPOS);
        check_eq("ovf_add_flags", W'(bus.out_flags), W'(4'b1001));
`endif
        check_eq("ovf_add_count", W'(bus.ovf_count), W'(1));

        // 5-5 gives zero with no borrow, visible one cycle after accept.
        cycle(1, 1, W'(5), W'(5), 1, 0);
        check_eq("sub_zero_valid", W'(bus.out_valid), W'(1));
        check_eq("sub_zero_flags", W'(bus.out_flags), W'(4'b0110));
        cycle(0, 0, '0, '0, 1, 0);

        // Three back-to-back with a stalled consumer, then drain in order.
        cycle(1, 0, W'(11), W'(1), 0, 0);
        cycle(1, 0, W'(22), W'(2), 0, 0);
        check_eq("full_in_ready", W'(bus.in_ready), '0);
        cycle(1, 0, W'(33), W'(3), 0, 0);
        cycle(1, 0, W'(33), W'(3), 0, 0);
        cycle(1, 0, W'(33), W'(3), 1, 0);
        cycle(1, 0, W'(33), W'(3), 1, 0);
        cycle(0, 0, '0, '0, 1, 0);
        cycle(0, 0, '0, '0, 1, 0);
        cycle(0, 0, '0, '0, 1, 1);

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ($urandom_range(3) == 0) b[W-1] = a[W-1];
            cycle(1'($urandom_range(1)), 1'($urandom_range(1)), a, b,
                  1'($urandom_range(3) != 0), $urandom_range(40) == 0);
        end

        // Saturation of the overflow counter, then clear beats a same-cycle increment.
        cycle(0, 0, '0, '0, 1, 1);
        cycle(0, 0, '0, '0, 1, 0);
        for (int i = 0; i < 65540; i++)
            cycle(1, 0, MAXPOS, W'(1), 1, 0);
        check_eq("cnt_saturated", W'(bus.ovf_count), W'(16'hFFFF));
        cycle(1, 0, MAXPOS, W'(1), 1, 1);
        check_eq("cnt_clear_prio", W'(bus.ovf_count), '0);
        cycle(1, 0, MAXPOS, W'(1), 1, 0);

        // Asynchronous reset with two buffered entries.
        cycle(1, 1, W'(9), W'(3), 0, 0);
        cycle(1, 1, W'(3), W'(9), 0, 0);
        check_eq("pre_rst_full", W'(bus.in_ready), '0);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_out_valid", W'(bus.out_valid), '0);
        check_eq("arst_ovf_count", W'(bus.ovf_count), '0);
        check_eq("arst_in_ready", W'(bus.in_ready), W'(1));
        check_eq("arst_out_result", bus.out_result, '0);
        q.delete();
        cnt_model = 0;
        @(negedge clk);
        rst = 1'b0;
        cycle(1, 1, W'(100), W'(1), 1, 0);
        check_eq("post_rst_latency", W'(bus.out_valid), W'(1));
        cycle(0, 0, '0, '0, 1, 0);
        cycle(0, 0, '0, '0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
